// File: rtl/gn_axis_arb_pkg.sv
// Shared definitions for the round-robin AXI-Stream arbiters.
//   ST_IDLE / ST_LOCKED : arbiter FSM state encoding (1-bit, legacy-compatible)
//   clog2_min1()        : ceil(log2(n)) clamped to at least 1, used to size
//                         grant index buses
package gn_axis_arb_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/gn_axis_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per port
//   last    : index of the most recently served port
//   any_req : at least one request present
//   grant   : first requesting port scanning last+1, last+2, ... (mod ports)
module gn_axis_rr_pick
    import gn_axis_arb_pkg::*;
#(
    parameter  int P_NUM_PORTS = 4,
    localparam int P_IDW       = clog2_min1(P_NUM_PORTS)
) (
    input  logic [P_NUM_PORTS-1:0] req,
    input  logic [P_IDW-1:0]       last,
    output logic                   any_req,
    output logic [P_IDW-1:0]       grant
);

    // Port index k positions after 'from', wrapped into 0..P_NUM_PORTS-1.
    function automatic logic [P_IDW-1:0] step_idx(input logic [P_IDW-1:0] from, input int k);
        return P_IDW'((int'(from) + k) % P_NUM_PORTS);
    endfunction

    // Scan from the farthest candidate down to the nearest so the nearest
    // requester after 'last' is the one left standing.
    always_comb begin
        any_req = |req;
        grant   = '0;
        for (int k = P_NUM_PORTS; k >= 1; k--) begin
            if (req[step_idx(last, k)]) grant = step_idx(last, k);
        end
    end

endmodule

// File: rtl/gn_axis_rr_arb.sv
// N-to-1 AXI-Stream round-robin arbiter with packet lock and a registered
// output stage. A granted port owns the output until its tlast beat is taken.
//   clk, reset_n   : clock, synchronous active-low reset
//   s_axis_*       : per-port slave streams (tdata packed port-major)
//   m_axis_*       : registered master stream
// Optional macro GN_AXIS_ARB_TID_EN adds m_axis_tid (source port index,
// registered with tdata) and o_busy (high while a packet is locked).
module gn_axis_rr_arb
    import gn_axis_arb_pkg::*;
#(
    parameter  int P_NUM_PORTS = 4,
    parameter  int P_DWIDTH    = 32,
    localparam int P_IDW       = clog2_min1(P_NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [P_NUM_PORTS*P_DWIDTH-1:0] s_axis_tdata,
    input  logic [P_NUM_PORTS-1:0]          s_axis_tvalid,
    input  logic [P_NUM_PORTS-1:0]          s_axis_tlast,
    output logic [P_NUM_PORTS-1:0]          s_axis_tready,
    output logic [P_DWIDTH-1:0]             m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
`ifdef GN_AXIS_ARB_TID_EN
    output logic [P_IDW-1:0]                m_axis_tid,
    output logic                            o_busy,
`endif
    input  logic                            m_axis_tready
);

    logic [0:0]          state;
    logic [P_IDW-1:0]    r_grant;
    logic [P_IDW-1:0]    r_last;
    logic [P_IDW-1:0]    pick_idx;
    logic                any_req;
    logic                out_ready;
    logic                accept;
    logic [P_DWIDTH-1:0] port_data [P_NUM_PORTS];

    for (genvar i = 0; i < P_NUM_PORTS; i++) begin : g_unpack
        assign port_data[i] = s_axis_tdata[i*P_DWIDTH +: P_DWIDTH];
    end

    gn_axis_rr_pick #(
        .P_NUM_PORTS (P_NUM_PORTS)
    ) u_pick (
        .req     (s_axis_tvalid),
        .last    (r_last),
        .any_req (any_req),
        .grant   (pick_idx)
    );

    // Output stage can take a beat when empty or draining this cycle.
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign accept    = (state == ST_LOCKED) && s_axis_tvalid[r_grant] && out_ready;

    always_comb begin
        s_axis_tready = '0;
        if (state == ST_LOCKED) s_axis_tready[r_grant] = out_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            r_grant       <= '0;
            r_last        <= P_IDW'(P_NUM_PORTS - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        r_grant <= pick_idx;
                        state   <= ST_LOCKED;
                    end
                end
                default: begin
                    if (accept && s_axis_tlast[r_grant]) begin
                        r_last <= r_grant;
                        state  <= ST_IDLE;
                    end
                end
            endcase

            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= port_data[r_grant];
                m_axis_tlast  <= s_axis_tlast[r_grant];
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef GN_AXIS_ARB_TID_EN
    always_ff @(posedge clk) begin
        if (!reset_n)    m_axis_tid <= '0;
        else if (accept) m_axis_tid <= r_grant;
    end

    assign o_busy = (state == ST_LOCKED);
`endif

endmodule
